// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - bi, LSB first, one full-subtractor cell plus a borrow flop.
// Latency: done pulses WIDTH+1 cycles after the accepting edge; one operation per WIDTH+2 cycles.
// Backpressure: start_ready is high only in IDLE; start_valid is ignored otherwise (no queueing).
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   output logic [WIDTH-1:0] diff,
   output logic             bo,
   output logic             done,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] sd_q, sd_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bo_q, bo_d;

   // The single full-subtractor cell operating on the current LSBs.
   logic sub_bit;
   logic sub_borrow;
   assign sub_bit    = sa_q[0] ^ sb_q[0] ^ br_q;
   assign sub_borrow = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);

   // State and datapath registers; reset aborts any operation without touching results later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         sd_q    <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bo_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sd_q    <= sd_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bo_q    <= bo_d;
      end
   end

   // Next-state, datapath update and state-decoded status outputs.
   always_comb begin
      state_d     = state_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      sd_d        = sd_q;
      br_d        = br_q;
      cnt_d       = cnt_q;
      diff_d      = diff_q;
      bo_d        = bo_q;
      start_ready = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;

      case (state_q)
         IDLE: begin
            start_ready = 1'b1;
            busy        = 1'b0;
            if (start_valid) begin
               sa_d    = a;
               sb_d    = b;
               br_d    = bi;
               sd_d    = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sa_d = sa_q >> 1;
            sb_d = sb_q >> 1;
            // Shift then overwrite the MSB so WIDTH=1 needs no special slice.
            sd_d            = sd_q >> 1;
            sd_d[WIDTH-1]   = sub_bit;
            br_d            = sub_borrow;
            cnt_d           = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               // Results are captured only here, so they hold across later operations.
               diff_d  = sd_d;
               bo_d    = sub_borrow;
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign diff = diff_q;
   assign bo   = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and model-checked bench for serial_subtractor at WIDTH=8, 1 and 13.
// Inputs driven and outputs sampled on the falling clock edge.
// Every check is an immediate assertion; the summary reports totals.
module tb_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  sv  = 3'b000;
   logic [63:0] a_in  = '0;
   logic [63:0] b_in  = '0;
   logic        bi_in = 1'b0;

   logic        rdy8, bo8, done8, busy8;
   logic [7:0]  diff8;
   logic        rdy1, bo1, done1, busy1;
   logic [0:0]  diff1;
   logic        rdy13, bo13, done13, busy13;
   logic [12:0] diff13;

   int n_vec = 0;
   int n_err = 0;
   int sel   = 0;

   logic        m_rdy, m_bo, m_done, m_busy;
   logic [63:0] m_diff;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .start_valid(sv[0]), .start_ready(rdy8),
      .a(a_in[7:0]), .b(b_in[7:0]), .bi(bi_in),
      .diff(diff8), .bo(bo8), .done(done8), .busy(busy8)
   );

   serial_subtractor #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .start_valid(sv[1]), .start_ready(rdy1),
      .a(a_in[0:0]), .b(b_in[0:0]), .bi(bi_in),
      .diff(diff1), .bo(bo1), .done(done1), .busy(busy1)
   );

   serial_subtractor #(.WIDTH(13)) u_w13 (
      .clk(clk), .rst(rst), .start_valid(sv[2]), .start_ready(rdy13),
      .a(a_in[12:0]), .b(b_in[12:0]), .bi(bi_in),
      .diff(diff13), .bo(bo13), .done(done13), .busy(busy13)
   );

   // Route the instance under test to one set of monitor signals.
   always_comb begin
      m_rdy  = rdy8;
      m_bo   = bo8;
      m_done = done8;
      m_busy = busy8;
      m_diff = {56'd0, diff8};
      if (sel == 1) begin
         m_rdy  = rdy1;
         m_bo   = bo1;
         m_done = done1;
         m_busy = busy1;
         m_diff = {63'd0, diff1};
      end else if (sel == 2) begin
         m_rdy  = rdy13;
         m_bo   = bo13;
         m_done = done13;
         m_busy = busy13;
         m_diff = {51'd0, diff13};
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_status(input string tag, input logic r, input logic bz, input logic dn);
      chk({tag, ".start_ready"}, {63'd0, m_rdy},  {63'd0, r});
      chk({tag, ".busy"},        {63'd0, m_busy}, {63'd0, bz});
      chk({tag, ".done"},        {63'd0, m_done}, {63'd0, dn});
   endtask

   function automatic int width_of(input int s);
      return (s == 1) ? 1 : (s == 2) ? 13 : 8;
   endfunction

   // Full operation on instance s, starting at a falling edge with the block idle.
   task automatic op(input int s, input logic [63:0] a, input logic [63:0] b, input logic bi,
                     input logic [63:0] exp_diff, input logic exp_bo, input string tag);
      int w;
      w     = width_of(s);
      sel   = s;
      a_in  = a;
      b_in  = b;
      bi_in = bi;
      sv[s] = 1'b1;
      #1;
      chk({tag, ".ready_before"}, {63'd0, m_rdy}, 64'd1);
      @(posedge clk);
      for (int c = 1; c <= w; c++) begin
         @(negedge clk);
         if (c == 1) begin
            sv[s] = 1'b0;
            a_in  = {$urandom, $urandom};
            b_in  = {$urandom, $urandom};
            bi_in = 1'($urandom);
         end
         chk_status({tag, ".shift"}, 1'b0, 1'b1, 1'b0);
      end
      @(negedge clk);
      chk_status({tag, ".donecyc"}, 1'b0, 1'b1, 1'b1);
      chk({tag, ".diff"}, m_diff, exp_diff);
      chk({tag, ".bo"}, {63'd0, m_bo}, {63'd0, exp_bo});
      @(negedge clk);
      chk_status({tag, ".idle"}, 1'b1, 1'b0, 1'b0);
      chk({tag, ".diff_hold"}, m_diff, exp_diff);
   endtask

   // Reference model: {bo,diff} = {1'b0,a} - b - bi within w bits.
   task automatic rand_op(input int s, input string tag);
      int          w;
      logic [63:0] m, a, b;
      logic        bi;
      logic [64:0] r;
      w  = width_of(s);
      m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      a  = {$urandom, $urandom} & m;
      b  = {$urandom, $urandom} & m;
      bi = 1'($urandom);
      r  = {1'b0, a} - {1'b0, b} - {64'd0, bi};
      op(s, a, b, bi, r[63:0] & m, r[64], tag);
   endtask

   initial begin
      // Reset state.
      sel = 0;
      repeat (2) @(negedge clk);
      chk_status("reset", 1'b1, 1'b0, 1'b0);
      chk("reset.diff", m_diff, 64'd0);
      chk("reset.bo", {63'd0, m_bo}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // WIDTH=8 directed vectors.
      op(0, 64'h5A, 64'h23, 1'b0, 64'h37, 1'b0, "w8_5a_23");
      op(0, 64'h00, 64'h01, 1'b0, 64'hFF, 1'b1, "w8_00_01");
      op(0, 64'h80, 64'h80, 1'b1, 64'hFF, 1'b1, "w8_80_80_bi");
      op(0, 64'hFF, 64'h00, 1'b1, 64'hFE, 1'b0, "w8_ff_00_bi");

      // start_valid held high: back-to-back handshakes at edges 0 and 10.
      sel   = 0;
      a_in  = 64'h10;
      b_in  = 64'h01;
      bi_in = 1'b0;
      sv[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_in = 64'h03;
      b_in = 64'h05;
      for (int c = 2; c <= 8; c++) begin
         @(negedge clk);
         if (c == 4) a_in = 64'hAA;
      end
      a_in = 64'h03;
      @(negedge clk);
      chk_status("held.c9", 1'b0, 1'b1, 1'b1);
      chk("held.c9.diff", m_diff, 64'h0F);
      chk("held.c9.bo", {63'd0, m_bo}, 64'd0);
      @(negedge clk);
      chk_status("held.c10", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk_status("held.c11", 1'b0, 1'b1, 1'b0);
      a_in = 64'h77;
      b_in = 64'h11;
      for (int c = 12; c <= 18; c++) @(negedge clk);
      @(negedge clk);
      chk_status("held.c19", 1'b0, 1'b1, 1'b1);
      chk("held.c19.diff", m_diff, 64'hFE);
      chk("held.c19.bo", {63'd0, m_bo}, 64'd1);
      sv[0] = 1'b0;
      @(negedge clk);
      chk_status("held.c20", 1'b1, 1'b0, 1'b0);

      // Asynchronous reset mid-SHIFT clears results immediately, no done pulse.
      a_in  = 64'h00;
      b_in  = 64'h01;
      bi_in = 1'b0;
      sv[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sv[0] = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk_status("arst", 1'b1, 1'b0, 1'b0);
      chk("arst.diff", m_diff, 64'd0);
      chk("arst.bo", {63'd0, m_bo}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("arst.no_done", {63'd0, m_done}, 64'd0);
      end
      op(0, 64'h05, 64'h03, 1'b0, 64'h02, 1'b0, "w8_after_rst");

      // WIDTH=1: full truth table.
      op(1, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, "w1_000");
      op(1, 64'd0, 64'd0, 1'b1, 64'd1, 1'b1, "w1_001");
      op(1, 64'd0, 64'd1, 1'b0, 64'd1, 1'b1, "w1_010");
      op(1, 64'd0, 64'd1, 1'b1, 64'd0, 1'b1, "w1_011");
      op(1, 64'd1, 64'd0, 1'b0, 64'd1, 1'b0, "w1_100");
      op(1, 64'd1, 64'd0, 1'b1, 64'd0, 1'b0, "w1_101");
      op(1, 64'd1, 64'd1, 1'b0, 64'd0, 1'b0, "w1_110");
      op(1, 64'd1, 64'd1, 1'b1, 64'd1, 1'b1, "w1_111");

      // WIDTH=13 boundary vectors.
      op(2, 64'h1FFF, 64'h0000, 1'b0, 64'h1FFF, 1'b0, "w13_max");
      op(2, 64'h0000, 64'h1FFF, 1'b1, 64'h0000, 1'b1, "w13_wrap");

      // Random operations against the reference model.
      for (int i = 0; i < 1000; i++) rand_op(0, "w8_rand");
      for (int i = 0; i < 1000; i++) rand_op(2, "w13_rand");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
